if_fetch: RTL

- Instruction fetch unit; the producing end of the instruction/address interface consumed by the decode stage.
- Holds the PC and issues in-order word fetches to instruction memory over a req/gnt/rvalid handshake.
- Buffers returned words in a small FIFO and presents one instruction per cycle to decode.
- Handles stall (hold) and redirect (jump/branch flush); discards stale in-flight responses after a redirect.

---
 rtl/if_fetch.sv | 116 +++++++++++
 1 files changed

// File: rtl/if_fetch.sv
// if_fetch: instruction fetch unit; PC, req/gnt/rvalid memory port, fetch buffer and decode output stage.
// Optional feature macro: IF_FETCH_MISALIGN_CHECK_EN (adds ins_misalign_o, blocks fetch after a misaligned redirect).
module if_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [31:0] NOP_INSN   = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        jump_flag_i,
    input  logic [31:0] jump_addr_i,
    input  logic        hold_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] ins_o,
    output logic [31:0] ins_addr_o,
    output logic        ins_valid_o
`ifdef IF_FETCH_MISALIGN_CHECK_EN
    ,
    output logic        ins_misalign_o
`endif
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    logic [31:0]   pc;
    logic [31:0]   resp_pc;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] drop_cnt;
    logic [CW-1:0] fifo_count;
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic [31:0]   fifo_data [FIFO_DEPTH];
    logic [31:0]   fifo_addr [FIFO_DEPTH];
    logic          blocked;
    logic          grant;
    logic          push;
    logic          pop;

    assign fifo_count  = wr_ptr - rd_ptr;
    assign imem_addr_o = pc;
    assign imem_req_o  = !rst && !jump_flag_i && !blocked &&
                         ((CW+1)'(outstanding) + (CW+1)'(fifo_count) < (CW+1)'(FIFO_DEPTH));
    assign grant       = imem_req_o && imem_gnt_i;
    assign push        = imem_rvalid_i && !jump_flag_i && drop_cnt == '0;
    assign pop         = !jump_flag_i && !hold_i && fifo_count != '0;

    // PC, response tracking and buffer pointers; a redirect marks every in-flight response stale
    always_ff @(posedge clk) begin
        if (rst) begin
            pc          <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
        end else begin
            outstanding <= outstanding + CW'(grant) - CW'(imem_rvalid_i);
            if (jump_flag_i) begin
                pc       <= jump_addr_i;
                resp_pc  <= jump_addr_i;
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                drop_cnt <= outstanding - CW'(imem_rvalid_i);
            end else begin
                if (grant) pc <= pc + 32'd4;
                if (push) begin
                    resp_pc <= resp_pc + 32'd4;
                    wr_ptr  <= wr_ptr + 1'b1;
                end
                if (pop) rd_ptr <= rd_ptr + 1'b1;
                if (imem_rvalid_i && drop_cnt != '0) drop_cnt <= drop_cnt - 1'b1;
            end
        end
    end

    // buffer storage: returned word paired with the address it was fetched from
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data[wr_ptr[AW-1:0]] <= imem_rdata_i;
            fifo_addr[wr_ptr[AW-1:0]] <= resp_pc;
        end
    end

    // decode-facing register: redirect flushes, hold freezes, otherwise pop or bubble
    always_ff @(posedge clk) begin
        if (rst) begin
            ins_o       <= NOP_INSN;
            ins_addr_o  <= RESET_PC;
            ins_valid_o <= 1'b0;
        end else if (pop) begin
            ins_o       <= fifo_data[rd_ptr[AW-1:0]];
            ins_addr_o  <= fifo_addr[rd_ptr[AW-1:0]];
            ins_valid_o <= 1'b1;
        end else if (jump_flag_i || !hold_i) begin
            ins_o       <= NOP_INSN;
            ins_valid_o <= 1'b0;
        end
    end

`ifdef IF_FETCH_MISALIGN_CHECK_EN
    // misaligned redirect target latches an error and stops fetching until the next redirect
    always_ff @(posedge clk) begin
        if (rst) ins_misalign_o <= 1'b0;
        else if (jump_flag_i) ins_misalign_o <= jump_addr_i[1:0] != 2'b00;
    end
    assign blocked = ins_misalign_o;
`else
    assign blocked = 1'b0;
`endif

endmodule
